// File: rtl/sccb_target.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_target
//  Purpose  : SCCB target (responder) with OV5640-style 16-bit register
//             addressing. Decodes 3-phase writes and 2-phase write / 2-phase
//             read sequences. Writes and read requests are presented on a
//             simple register port.
//  Ports    : sys_clk, sys_rst       - system clock, sync active-high reset
//             sccb_sioc, sccb_siod_i - asynchronous bus line levels
//             sccb_siod_oe           - 1 = pull SIOD low (open drain)
//             wr_en/wr_addr/wr_data  - one-cycle register write strobe
//             rd_addr/rd_data        - address pointer and its contents
//             busy                   - transaction in progress
//  Revision : 1.0 - initial release
// ============================================================================
module sccb_target #(
    parameter logic [6:0] DEV_ID = 7'h3C
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sccb_sioc,
    input  logic        sccb_siod_i,
    output logic        sccb_siod_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DEV     = 4'd1,
        S_ACK_DEV = 4'd2,
        S_ADDR_H  = 4'd3,
        S_ACK_H   = 4'd4,
        S_ADDR_L  = 4'd5,
        S_ACK_L   = 4'd6,
        S_WDATA   = 4'd7,
        S_ACK_W   = 4'd8,
        S_RDATA   = 4'd9,
        S_RACK    = 4'd10,
        S_IGNORE  = 4'd11
    } state_t;

    // [0],[1] form the synchronizer; [2] is the edge-detect history.
    logic [2:0]  r_sioc_sync_q, w_sioc_sync_d;
    logic [2:0]  r_siod_sync_q, w_siod_sync_d;
    state_t      r_state_q,     w_state_d;
    logic [3:0]  r_bit_cnt_q,   w_bit_cnt_d;
    logic [7:0]  r_shift_q,     w_shift_d;
    logic        r_is_read_q,   w_is_read_d;
    logic        r_oe_q,        w_oe_d;
    logic        r_wr_en_q,     w_wr_en_d;
    logic [15:0] r_wr_addr_q,   w_wr_addr_d;
    logic [7:0]  r_wr_data_q,   w_wr_data_d;
    logic [15:0] r_rd_addr_q,   w_rd_addr_d;
    logic        r_busy_q,      w_busy_d;

    logic w_sioc_high, w_siod_lvl;
    logic w_sioc_rise, w_sioc_fall;
    logic w_start, w_stop;

    assign w_sioc_high = r_sioc_sync_q[1];
    assign w_siod_lvl  = r_siod_sync_q[1];
    assign w_sioc_rise =  r_sioc_sync_q[1] & ~r_sioc_sync_q[2];
    assign w_sioc_fall = ~r_sioc_sync_q[1] &  r_sioc_sync_q[2];
    assign w_start     = ~r_siod_sync_q[1] &  r_siod_sync_q[2] & w_sioc_high;
    assign w_stop      =  r_siod_sync_q[1] & ~r_siod_sync_q[2] & w_sioc_high;

    always_comb begin
        w_sioc_sync_d = {r_sioc_sync_q[1:0], sccb_sioc};
        w_siod_sync_d = {r_siod_sync_q[1:0], sccb_siod_i};
        w_state_d     = r_state_q;
        w_bit_cnt_d   = r_bit_cnt_q;
        w_shift_d     = r_shift_q;
        w_is_read_d   = r_is_read_q;
        w_oe_d        = r_oe_q;
        w_wr_en_d     = 1'b0;
        w_wr_addr_d   = r_wr_addr_q;
        w_wr_data_d   = r_wr_data_q;
        // Post-write increment lands the cycle after the strobe so that
        // wr_addr captures the pre-increment pointer.
        w_rd_addr_d   = r_wr_en_q ? r_rd_addr_q + 16'd1 : r_rd_addr_q;

        // Bus conditions outrank any bit sampled on the same SIOC edge.
        if (w_start) begin
            w_state_d   = S_DEV;
            w_bit_cnt_d = 4'd0;
            w_oe_d      = 1'b0;
        end else if (w_stop) begin
            w_state_d   = S_IDLE;
            w_bit_cnt_d = 4'd0;
            w_oe_d      = 1'b0;
        end else begin
            case (r_state_q)
                S_DEV, S_ADDR_H, S_ADDR_L, S_WDATA: begin
                    if (w_sioc_rise && r_bit_cnt_q != 4'd8) begin
                        w_shift_d   = {r_shift_q[6:0], w_siod_lvl};
                        w_bit_cnt_d = r_bit_cnt_q + 4'd1;
                    end else if (w_sioc_fall && r_bit_cnt_q == 4'd8) begin
                        // Fall ending bit 8: decide the ACK slot.
                        w_bit_cnt_d = 4'd0;
                        w_oe_d      = 1'b1;
                        case (r_state_q)
                            S_DEV: begin
                                if (r_shift_q[7:1] == DEV_ID) begin
                                    w_state_d   = S_ACK_DEV;
                                    w_is_read_d = r_shift_q[0];
                                end else begin
                                    w_state_d = S_IGNORE;
                                    w_oe_d    = 1'b0;
                                end
                            end
                            S_ADDR_H: begin
                                w_state_d          = S_ACK_H;
                                w_rd_addr_d[15:8]  = r_shift_q;
                            end
                            S_ADDR_L: begin
                                w_state_d          = S_ACK_L;
                                w_rd_addr_d[7:0]   = r_shift_q;
                            end
                            default: begin
                                w_state_d   = S_ACK_W;
                                w_wr_en_d   = 1'b1;
                                w_wr_addr_d = r_rd_addr_q;
                                w_wr_data_d = r_shift_q;
                            end
                        endcase
                    end
                end
                // ACK states are entered on a fall, so the next fall is the
                // one that closes the ACK slot.
                S_ACK_DEV: begin
                    if (w_sioc_fall) begin
                        if (r_is_read_q) begin
                            w_state_d   = S_RDATA;
                            w_shift_d   = rd_data;
                            w_oe_d      = ~rd_data[7];
                            w_bit_cnt_d = 4'd0;
                        end else begin
                            w_state_d = S_ADDR_H;
                            w_oe_d    = 1'b0;
                        end
                    end
                end
                S_ACK_H: begin
                    if (w_sioc_fall) begin
                        w_state_d = S_ADDR_L;
                        w_oe_d    = 1'b0;
                    end
                end
                S_ACK_L, S_ACK_W: begin
                    if (w_sioc_fall) begin
                        w_state_d = S_WDATA;
                        w_oe_d    = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (w_sioc_rise && r_bit_cnt_q != 4'd8) begin
                        w_bit_cnt_d = r_bit_cnt_q + 4'd1;
                    end else if (w_sioc_fall && r_bit_cnt_q == 4'd8) begin
                        w_state_d   = S_RACK;
                        w_oe_d      = 1'b0;
                        w_bit_cnt_d = 4'd0;
                    end else if (w_sioc_fall && r_bit_cnt_q != 4'd0) begin
                        w_shift_d = {r_shift_q[6:0], 1'b0};
                        w_oe_d    = ~r_shift_q[6];
                    end
                end
                S_RACK: begin
                    // Rise samples the master's ACK; a later fall (reached
                    // only after an ACK) starts the next read byte.
                    if (w_sioc_rise) begin
                        if (w_siod_lvl) begin
                            w_state_d = S_IGNORE;
                        end else begin
                            w_rd_addr_d = r_rd_addr_q + 16'd1;
                        end
                    end else if (w_sioc_fall) begin
                        w_state_d   = S_RDATA;
                        w_shift_d   = rd_data;
                        w_oe_d      = ~rd_data[7];
                        w_bit_cnt_d = 4'd0;
                    end
                end
                default: ;
            endcase
        end

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sioc_sync_q <= 3'b111;
            r_siod_sync_q <= 3'b111;
            r_state_q     <= S_IDLE;
            r_bit_cnt_q   <= 4'd0;
            r_shift_q     <= 8'h00;
            r_is_read_q   <= 1'b0;
            r_oe_q        <= 1'b0;
            r_wr_en_q     <= 1'b0;
            r_wr_addr_q   <= 16'h0000;
            r_wr_data_q   <= 8'h00;
            r_rd_addr_q   <= 16'h0000;
            r_busy_q      <= 1'b0;
        end else begin
            r_sioc_sync_q <= w_sioc_sync_d;
            r_siod_sync_q <= w_siod_sync_d;
            r_state_q     <= w_state_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_shift_q     <= w_shift_d;
            r_is_read_q   <= w_is_read_d;
            r_oe_q        <= w_oe_d;
            r_wr_en_q     <= w_wr_en_d;
            r_wr_addr_q   <= w_wr_addr_d;
            r_wr_data_q   <= w_wr_data_d;
            r_rd_addr_q   <= w_rd_addr_d;
            r_busy_q      <= w_busy_d;
        end
    end

    assign sccb_siod_oe = r_oe_q;
    assign wr_en        = r_wr_en_q;
    assign wr_addr      = r_wr_addr_q;
    assign wr_data      = r_wr_data_q;
    assign rd_addr      = r_rd_addr_q;
    assign busy         = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sccb_target
//  Purpose  : Self-checking bench for sccb_target. A bus-master model drives
//             SIOC/SIOD (open drain), expected register writes are queued
//             before each data byte and matched against every wr_en strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_target;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        m_scl   = 1'b1;
    logic        m_sda   = 1'b1;
    logic        siod_line;
    logic        sccb_siod_oe;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;
    logic oe_seen  = 1'b0;

    assign siod_line = m_sda & ~sccb_siod_oe;
    assign rd_data   = (rd_addr == 16'h300A) ? 8'h56 : (rd_addr[7:0] ^ 8'hA5);

    always #5 sys_clk = ~sys_clk;

    sccb_target #(.DEV_ID(7'h3C)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .sccb_sioc    (m_scl),
        .sccb_siod_i  (siod_line),
        .sccb_siod_oe (sccb_siod_oe),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    // Scoreboard consumer: every strobe must match the oldest queued write.
    always @(negedge sys_clk) begin : p_mon
        wr_t e;
        if (sccb_siod_oe) oe_seen = 1'b1;
        if (!sys_rst && wr_en) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_strobe unexpected: got addr=%h data=%h, none expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== {e.a, e.d}) begin
                    errors++;
                    $display("FAIL wr_strobe: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clks(5);
        m_scl = 1'b1; wait_clks(10);
        m_sda = 1'b0; wait_clks(10);
        m_scl = 1'b0; wait_clks(10);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clks(5);
        m_scl = 1'b1; wait_clks(10);
        m_sda = 1'b1; wait_clks(20);
    endtask

    task automatic bit_out(input logic b);
        m_sda = b;    wait_clks(5);
        m_scl = 1'b1; wait_clks(20);
        m_scl = 1'b0; wait_clks(15);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        m_sda = 1'b1; wait_clks(5);
        m_scl = 1'b1; wait_clks(10);
        a = siod_line; wait_clks(10);
        m_scl = 1'b0; wait_clks(15);
        checks++;
        if (a !== exp_ack) begin
            errors++;
            $display("FAIL %s ack slot: line=%b expected=%b", name, a, exp_ack);
        end
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; wait_clks(5);
            m_scl = 1'b1; wait_clks(10);
            b[i] = siod_line; wait_clks(10);
            m_scl = 1'b0; wait_clks(15);
        end
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check_drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing strobes: %0d pending, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        wait_clks(5);
        sys_rst = 1'b0;
        wait_clks(2);
        check16("reset oe",      {15'd0, sccb_siod_oe}, 16'h0000);
        check16("reset wr_en",   {15'd0, wr_en},        16'h0000);
        check16("reset wr_addr", wr_addr,               16'h0000);
        check16("reset wr_data", {8'd0, wr_data},       16'h0000);
        check16("reset rd_addr", rd_addr,               16'h0000);
        check16("reset busy",    {15'd0, busy},         16'h0000);
    endtask

    task automatic test_write();
        bus_start();
        check16("write busy after start", {15'd0, busy}, 16'h0001);
        send_byte(8'h78, 1'b0, "write id");
        send_byte(8'h30, 1'b0, "write addr_h");
        send_byte(8'h08, 1'b0, "write addr_l");
        push_wr(16'h3008, 8'h82);
        send_byte(8'h82, 1'b0, "write data");
        bus_stop();
        check16("write rd_addr", rd_addr, 16'h3009);
        check16("write busy after stop", {15'd0, busy}, 16'h0000);
        check_drain("write");
    endtask

    task automatic test_read();
        logic [7:0] b;
        int w0;
        bus_start();
        send_byte(8'h78, 1'b0, "read set id");
        send_byte(8'h30, 1'b0, "read set addr_h");
        send_byte(8'h0A, 1'b0, "read set addr_l");
        bus_stop();
        w0 = wr_count;
        bus_start();
        send_byte(8'h79, 1'b0, "read id");
        read_byte(b);
        bit_out(1'b1);
        bus_stop();
        check16("read data", {8'd0, b}, 16'h0056);
        check16("read rd_addr", rd_addr, 16'h300A);
        check16("read no strobe", wr_count[15:0], w0[15:0]);
    endtask

    task automatic test_wrong_id();
        int w0;
        w0 = wr_count;
        oe_seen = 1'b0;
        bus_start();
        send_byte(8'h42, 1'b1, "wrong id");
        send_byte(8'h11, 1'b1, "wrong id follow");
        bus_stop();
        check16("wrong id oe", {15'd0, oe_seen}, 16'h0000);
        check16("wrong id no strobe", wr_count[15:0], w0[15:0]);
        bus_start();
        send_byte(8'h78, 1'b0, "after wrong id");
        send_byte(8'h12, 1'b0, "after wrong addr_h");
        send_byte(8'h34, 1'b0, "after wrong addr_l");
        push_wr(16'h1234, 8'h99);
        send_byte(8'h99, 1'b0, "after wrong data");
        bus_stop();
        check_drain("after wrong id");
        check16("after wrong rd_addr", rd_addr, 16'h1235);
    endtask

    task automatic test_burst_wrap();
        bus_start();
        send_byte(8'h78, 1'b0, "burst id");
        send_byte(8'hFF, 1'b0, "burst addr_h");
        send_byte(8'hFF, 1'b0, "burst addr_l");
        push_wr(16'hFFFF, 8'hA1);
        push_wr(16'h0000, 8'hA2);
        send_byte(8'hA1, 1'b0, "burst data0");
        send_byte(8'hA2, 1'b0, "burst data1");
        bus_stop();
        check_drain("burst");
        check16("burst rd_addr", rd_addr, 16'h0001);
    endtask

    task automatic test_abort();
        int w0;
        w0 = wr_count;
        bus_start();
        send_byte(8'h78, 1'b0, "abort id");
        send_byte(8'h40, 1'b0, "abort addr_h");
        send_byte(8'h00, 1'b0, "abort addr_l");
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1); bit_out(1'b0);
        bus_stop();
        check16("abort no strobe", wr_count[15:0], w0[15:0]);
        check16("abort busy", {15'd0, busy}, 16'h0000);
        check16("abort rd_addr", rd_addr, 16'h4000);
        bus_start();
        send_byte(8'h78, 1'b0, "restart id");
        send_byte(8'h50, 1'b0, "restart addr_h");
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
        bus_start();
        send_byte(8'h78, 1'b0, "restart id2");
        send_byte(8'h51, 1'b0, "restart addr_h2");
        send_byte(8'h22, 1'b0, "restart addr_l2");
        push_wr(16'h5122, 8'h33);
        send_byte(8'h33, 1'b0, "restart data");
        bus_stop();
        check_drain("restart");
        check16("restart busy", {15'd0, busy}, 16'h0000);
    endtask

    task automatic test_reset_ack();
        int n;
        bus_start();
        for (int i = 7; i >= 0; i--) bit_out(i[2:0] == 3'd6 || i[2:0] == 3'd5 ||
                                            i[2:0] == 3'd4 || i[2:0] == 3'd3);
        n = 0;
        while (!sccb_siod_oe && n < 100) begin
            wait_clks(1);
            n++;
        end
        checks++;
        if (!sccb_siod_oe) begin
            errors++;
            $display("FAIL reset_ack oe never asserted: oe=%b expected=1", sccb_siod_oe);
        end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check16("reset_ack oe",      {15'd0, sccb_siod_oe}, 16'h0000);
        check16("reset_ack wr_en",   {15'd0, wr_en},        16'h0000);
        check16("reset_ack wr_addr", wr_addr,               16'h0000);
        check16("reset_ack wr_data", {8'd0, wr_data},       16'h0000);
        check16("reset_ack rd_addr", rd_addr,               16'h0000);
        check16("reset_ack busy",    {15'd0, busy},         16'h0000);
        m_sda = 1'b1; wait_clks(3);
        m_scl = 1'b1; wait_clks(3);
        sys_rst = 1'b0;
        wait_clks(10);
        check16("reset_ack idle busy", {15'd0, busy}, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_id();
        test_burst_wrap();
        test_abort();
        test_reset_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sccb_target.md
# sccb_target

Synthesizable SCCB target (responder) for the OV5640 subsystem: the other end of the bus driven by `sccb_master`. It decodes the 3-phase write and the 2-phase-write/2-phase-read sequences with OV5640-style 16-bit register addressing, ACKs its device ID, and presents writes and read requests on a simple register-port interface. It is used as a camera stand-in for loopback bring-up and for self-checking benches of the setup path.

## Interface
- `DEV_ID`, 7'h3C, 7-bit SCCB ID: write byte 0x78, read byte 0x79.
- `sys_clk`  in  1  system clock; must run at least 16× the SIOC rate.
- `sys_rst`  in  1  synchronous, active-high reset.
- `sccb_sioc`  in  1  SCCB clock from the master (asynchronous).
- `sccb_siod_i`  in  1  SIOD line level (asynchronous).
- `sccb_siod_oe`  out  1  1 = pull SIOD low; 0 = release. Open-drain: the pad is 0 when enabled and Z otherwise.
- `wr_en`  out  1  one-cycle strobe: `wr_addr`/`wr_data` are valid.
- `wr_addr`  out  16  register address of the write.
- `wr_data`  out  8  write data byte.
- `rd_addr`  out  16  current address pointer, always driven.
- `rd_data`  in  8  register contents at `rd_addr`; must be valid 1 cycle after `rd_addr` changes.
- `busy`  out  1  high from START detect until STOP or return to IDLE.

## Operation
- Synchronizers: SIOC and SIOD each pass through a 2-flop synchronizer.
- Edge detection: one extra register per line gives rise/fall pulses.
- START: SIOD falls while SIOC is high. Valid in any state, including as a repeated start. Clears the bit counter and goes to `DEV`. Any partial byte is discarded.
- STOP: SIOD rises while SIOC is high. Goes to `IDLE` from any state. A partial byte is discarded and produces no strobe.
- Bit sampling: SIOD is sampled on each SIOC rise, MSB first, 8 bits per byte. The 9th clock is the ACK slot.
- States: `IDLE`, `DEV`, `ACK_DEV`, `ADDR_H`, `ACK_H`, `ADDR_L`, `ACK_L`, `WDATA`, `ACK_W`, `RDATA`, `RACK`, `IGNORE`.
- `DEV` byte decode:
  - Byte[7:1] == `DEV_ID` and R/W = 0 → `ACK_DEV` → `ADDR_H`.
  - Byte[7:1] == `DEV_ID` and R/W = 1 → `ACK_DEV` → `RDATA`.
  - Mismatch → `IGNORE` with no ACK, waiting for START or STOP.
- Address bytes:
  - `ADDR_H` loads `rd_addr[15:8]`.
  - `ADDR_L` loads `rd_addr[7:0]`.
  - Both are ACKed.
- `WDATA` (after its ACK):
  - Issues the `wr_en` pulse with `wr_addr = rd_addr` and the received byte.
  - Then increments `rd_addr` (16-bit wrap, 0xFFFF → 0x0000) and stays in `WDATA` for burst writes.
- `RDATA`:
  - On the SIOC fall that ends `ACK_DEV` (or `RACK`), loads the shift register from `rd_data`.
  - Drives `sccb_siod_oe = ~bit` for each bit, shifting on each SIOC fall.
- `RACK`:
  - Target releases SIOD and samples the master's bit on SIOC rise.
  - Master ACK (0) → increment `rd_addr` and return to `RDATA`.
  - Master NACK (1) → `IGNORE`.
- ACK drive: `sccb_siod_oe` asserts on the detected SIOC fall that ends bit 8 and releases on the detected SIOC fall that ends the ACK slot.
- Address persistence: `rd_addr` survives STOP, so a write-phase address followed by a read phase reads that address.

## Timing
- Reset values: `sccb_siod_oe` 0, `wr_en` 0, `wr_addr` 0x0000, `wr_data` 0x00, `rd_addr` 0x0000, `busy` 0, state `IDLE`.
- Bus-event detection latency: 3 `sys_clk` cycles from pin edge to internal event.
- SIOD output change: follows the detected SIOC fall by 1 cycle, i.e. ≤ 4 cycles after the pin edge. This must fit well within SIOC-low time; the 16× ratio guarantees it.
- `wr_en`: high for exactly 1 cycle. It is issued on the cycle the WDATA ACK is asserted.
- `rd_addr`: increment is visible the cycle after the `wr_en` pulse, or the cycle after the RACK sample.
- Simultaneous SIOC rise with START/STOP detection: START/STOP takes priority over a data-bit sample.
- Reset mid-transaction: `sccb_siod_oe` drops to 0 on the first clock with `sys_rst` high. The FSM returns to `IDLE`, and all outputs take their reset values.
- `busy`: rises 1 cycle after START detect and falls 1 cycle after STOP detect.

## Test plan
- Write: 3-phase write ID 0x78, 0x30, 0x08, 0x82 → ACK on all 4 slots; one `wr_en` with `wr_addr` 0x3008 and `wr_data` 0x82; `rd_addr` then reads 0x3009.
- Read:
  - Stimulus: 2-phase write 0x78, 0x30, 0x0A, then STOP; 2-phase read 0x79 with `rd_data` = 0x56 and master NACK.
  - Required response: SIOD carries 0x56 MSB first; no `wr_en`; `rd_addr` stays 0x300A.
- Wrong ID: 0x42 sent → `sccb_siod_oe` never asserts and no strobes occur; the next valid 0x78 transaction is accepted normally.
- Burst write with wrap: address 0xFFFF, data 0xA1, 0xA2 → `wr_en` at 0xFFFF/0xA1, then at 0x0000/0xA2.
- Aborted byte: STOP after 5 bits of a data byte → no `wr_en`, `busy` falls, state `IDLE`. A repeated START mid-address restarts at `DEV`.
- Reset during an ACK slot: assert `sys_rst` while `sccb_siod_oe` = 1 → `sccb_siod_oe` is 0 the next cycle and all outputs are at reset values.
